// File: rtl/mbox_sender.sv
// SoC-side mailbox requester: lock, CMD/DLEN/data, EXECUTE, STATUS poll, response drain, release.
// Optional poll timeout is compiled in with CALIPTRA_MBOX_SENDER_TIMEOUT_EN.
module mbox_sender #(
  parameter int unsigned MBOX_SIZE_BYTES = 131072,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cmd,
  input  logic [31:0] dlen,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  resp_status,
  output logic [31:0] resp_dlen,
  output logic        err_oversize,
  output logic        err_fail,
  output logic        err_timeout,
  output logic        req_dv,
  output logic        req_write,
  output logic [2:0]  req_addr,
  output logic [31:0] req_wdata,
  input  logic        req_hold,
  input  logic [31:0] req_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOCK, S_CMD, S_DLEN, S_DATA, S_EXEC,
    S_STATUS, S_RDLEN, S_RDATA, S_RELEASE, S_DONE
  } state_t;

  localparam logic [2:0] A_LOCK    = 3'd0;
  localparam logic [2:0] A_CMD     = 3'd1;
  localparam logic [2:0] A_DLEN    = 3'd2;
  localparam logic [2:0] A_DATAIN  = 3'd3;
  localparam logic [2:0] A_DATAOUT = 3'd4;
  localparam logic [2:0] A_EXECUTE = 3'd5;
  localparam logic [2:0] A_STATUS  = 3'd6;

  state_t      state, next_state;
  logic [31:0] cmd_q, dlen_q, words, wcnt;
  logic        xfer, last_word, timeout_hit, start_ok;

  function automatic logic [31:0] word_count(input logic [31:0] nbytes);
    return {2'b00, nbytes[31:2]} + {31'd0, |nbytes[1:0]};
  endfunction

  assign xfer      = req_dv && !req_hold;
  assign last_word = (wcnt == words - 32'd1);
  assign start_ok  = (state == S_IDLE) && start;

`ifdef CALIPTRA_MBOX_SENDER_TIMEOUT_EN
  logic [31:0] tcnt;

  // Timeout only acts on a completing poll so req_dv never drops mid-stall.
  assign timeout_hit = (tcnt >= TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state != S_LOCK && state != S_STATUS) begin
      tcnt <= '0;
    end else if (tcnt != '1) begin
      tcnt <= tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (start_ok) begin
      err_timeout <= 1'b0;
    end else if (xfer && timeout_hit &&
                 ((state == S_LOCK && req_rdata[0]) ||
                  (state == S_STATUS && req_rdata[3:0] == 4'd0))) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_dv     = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    tx_ready   = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) next_state = (dlen > MBOX_SIZE_BYTES) ? S_DONE : S_LOCK;
      end
      S_LOCK: begin
        req_dv   = 1'b1;
        req_addr = A_LOCK;
        if (xfer) begin
          if (!req_rdata[0])    next_state = S_CMD;
          else if (timeout_hit) next_state = S_DONE;
        end
      end
      S_CMD: begin
        req_dv    = 1'b1;
        req_write = 1'b1;
        req_addr  = A_CMD;
        req_wdata = cmd_q;
        if (xfer) next_state = S_DLEN;
      end
      S_DLEN: begin
        req_dv    = 1'b1;
        req_write = 1'b1;
        req_addr  = A_DLEN;
        req_wdata = dlen_q;
        if (xfer) next_state = (words == 32'd0) ? S_EXEC : S_DATA;
      end
      S_DATA: begin
        tx_ready  = !req_hold;
        req_dv    = tx_valid;
        req_write = 1'b1;
        req_addr  = A_DATAIN;
        req_wdata = tx_data;
        if (xfer && last_word) next_state = S_EXEC;
      end
      S_EXEC: begin
        req_dv    = 1'b1;
        req_write = 1'b1;
        req_addr  = A_EXECUTE;
        req_wdata = 32'd1;
        if (xfer) next_state = S_STATUS;
      end
      S_STATUS: begin
        req_dv   = 1'b1;
        req_addr = A_STATUS;
        if (xfer) begin
          if (req_rdata[3:0] == 4'd1)      next_state = S_RDLEN;
          else if (req_rdata[3:0] != 4'd0) next_state = S_RELEASE;
          else if (timeout_hit)            next_state = S_RELEASE;
        end
      end
      S_RDLEN: begin
        req_dv   = 1'b1;
        req_addr = A_DLEN;
        if (xfer) begin
          next_state = (req_rdata > MBOX_SIZE_BYTES || req_rdata == 32'd0) ?
                       S_RELEASE : S_RDATA;
        end
      end
      S_RDATA: begin
        // Once issued the register stays empty until this read lands, so req_dv holds through stalls.
        req_dv   = !rx_valid || rx_ready;
        req_addr = A_DATAOUT;
        if (xfer && last_word) next_state = S_RELEASE;
      end
      S_RELEASE: begin
        req_dv    = 1'b1;
        req_write = 1'b1;
        req_addr  = A_EXECUTE;
        req_wdata = 32'd0;
        if (xfer) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q        <= '0;
      dlen_q       <= '0;
      words        <= '0;
      wcnt         <= '0;
      resp_status  <= '0;
      resp_dlen    <= '0;
      err_oversize <= 1'b0;
      err_fail     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q        <= cmd;
            dlen_q       <= dlen;
            words        <= word_count(dlen);
            wcnt         <= '0;
            resp_status  <= '0;
            resp_dlen    <= '0;
            err_fail     <= 1'b0;
            err_oversize <= (dlen > MBOX_SIZE_BYTES);
          end
        end
        S_DATA, S_RDATA: begin
          if (xfer) wcnt <= wcnt + 32'd1;
        end
        S_STATUS: begin
          if (xfer && req_rdata[3:0] != 4'd0) begin
            resp_status <= req_rdata[3:0];
            if (req_rdata[3:0] == 4'd3) err_fail <= 1'b1;
          end
        end
        S_RDLEN: begin
          if (xfer) begin
            resp_dlen <= req_rdata;
            words     <= word_count(req_rdata);
            wcnt      <= '0;
            if (req_rdata > MBOX_SIZE_BYTES) err_oversize <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (state == S_RDATA && xfer) begin
      rx_data  <= req_rdata;
      rx_valid <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mbox_sender.sv
// Directed bench for mbox_sender: a scripted mailbox model answers register accesses and logs them.
module tb_mbox_sender;

  logic        clk = 1'b0;
  logic        rst, start, tx_valid, tx_ready, rx_valid, rx_ready, busy, done;
  logic [31:0] cmd, dlen, tx_data, rx_data, resp_dlen, req_wdata, req_rdata;
  logic [3:0]  resp_status;
  logic        err_oversize, err_fail, err_timeout, req_dv, req_write, req_hold;
  logic [2:0]  req_addr;

  mbox_sender #(.MBOX_SIZE_BYTES(131072), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .dlen(dlen),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .resp_status(resp_status), .resp_dlen(resp_dlen),
    .err_oversize(err_oversize), .err_fail(err_fail), .err_timeout(err_timeout),
    .req_dv(req_dv), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_hold(req_hold), .req_rdata(req_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Mailbox and stream model state
  int unsigned lock_left, dout_idx, stat_idx, stat_len, tx_rd, tx_n, dv_cnt, done_cnt;
  int unsigned stab_viol, ovr_viol;
  logic [31:0] stat_seq [8];
  logic [31:0] tx_mem [8];
  logic [31:0] stat_dflt, mb_dlen;
  logic        tx_en;
  logic [35:0] acc_q [$];
  logic [31:0] rx_q [$];
  logic        pend_comp, pend_tx, prev_stall, p_write;
  logic [2:0]  pend_addr, p_addr;
  logic [31:0] p_wdata;

  assign tx_valid = tx_en && (tx_rd < tx_n);
  assign tx_data  = tx_mem[tx_rd[2:0]];

  always_comb begin
    case (req_addr)
      3'd0:    req_rdata = {31'd0, lock_left != 0};
      3'd2:    req_rdata = mb_dlen;
      3'd4:    req_rdata = 32'hD000_0000 + dout_idx;
      3'd6:    req_rdata = (stat_idx < stat_len) ? stat_seq[stat_idx[2:0]] : stat_dflt;
      default: req_rdata = 32'hDEAD_BEEF;
    endcase
  end

  // Inputs only change at posedge+1, so negedge values are the ones seen at the next edge.
  always @(negedge clk) begin
    pend_comp = req_dv && !req_hold;
    pend_addr = req_addr;
    pend_tx   = tx_valid && tx_ready;
    if (pend_comp) acc_q.push_back({req_write, req_addr, req_write ? req_wdata : 32'd0});
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    if (pend_comp && req_addr == 3'd4 && rx_valid && !rx_ready) ovr_viol++;
    if (prev_stall && (!req_dv || req_addr != p_addr || req_write != p_write || req_wdata != p_wdata))
      stab_viol++;
    prev_stall = req_dv && req_hold;
    p_addr = req_addr; p_write = req_write; p_wdata = req_wdata;
    if (req_dv) dv_cnt++;
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (pend_comp) begin
      case (pend_addr)
        3'd0: if (lock_left != 0) lock_left--;
        3'd4: dout_idx++;
        3'd6: stat_idx++;
        default: ;
      endcase
    end
    if (pend_tx) tx_rd++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned n_acc(input logic [3:0] wa);
    int unsigned n = 0;
    foreach (acc_q[i]) if (acc_q[i][35:32] == wa) n++;
    return n;
  endfunction

  task automatic start_txn(input logic [31:0] c, input logic [31:0] d);
    @(posedge clk); #1;
    acc_q.delete(); rx_q.delete();
    dv_cnt = 0; dout_idx = 0; stat_idx = 0;
    start = 1'b1; cmd = c; dlen = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done || n >= budget) break;
    end
    check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [2:0] a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_addr == a) break;
    end
    check({tag, "_reach"}, {61'd0, req_addr}, {61'd0, a});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  logic [35:0] exp_dr [11];
  int n, d0;
  logic [31:0] din [$];

  initial begin
    rst = 1'b1; start = 1'b0; cmd = '0; dlen = '0; tx_en = 1'b0; rx_ready = 1'b1; req_hold = 1'b0;
    lock_left = 0; dout_idx = 0; stat_idx = 0; stat_len = 0; stat_dflt = '0; mb_dlen = '0;
    tx_rd = 0; tx_n = 0; dv_cnt = 0; done_cnt = 0; stab_viol = 0; ovr_viol = 0;
    prev_stall = 1'b0; pend_comp = 1'b0; pend_tx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {56'd0, busy, done, req_dv, req_write, rx_valid, tx_ready, err_oversize, err_fail}, 64'd0);
    check("rst_resp", {28'd0, resp_status, resp_dlen}, 64'd0);
    check("rst_bus", {29'd0, req_addr, req_wdata}, 64'd0);
    check("rst_timeout", {63'd0, err_timeout}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Minimum transaction: dlen=0, CMD_COMPLETE first poll
    stat_seq[0] = 32'd2; stat_len = 1;
    start_txn(32'h1234_0000, 32'd0);
    check("start_to_req_dv", {60'd0, req_dv, req_addr}, {60'd0, 1'b1, 3'd0});
    wait_done("min", 50, n);
    check("min_cycles_to_done", n + 1, 8);
    check("min_acc_count", acc_q.size(), 6);
    if (acc_q.size() == 6) check("min_last_acc", acc_q[5], {1'b1, 3'd5, 32'd0});
    @(negedge clk);
    check("min_done_one_cycle", {62'd0, done, busy}, 64'd0);

    // DATA_READY response with payload in both directions
    exp_dr = '{{1'b0, 3'd0, 32'd0}, {1'b1, 3'd1, 32'hA5A5_0001}, {1'b1, 3'd2, 32'd8},
               {1'b1, 3'd3, 32'h1111_1111}, {1'b1, 3'd3, 32'h2222_2222}, {1'b1, 3'd5, 32'd1},
               {1'b0, 3'd6, 32'd0}, {1'b0, 3'd2, 32'd0}, {1'b0, 3'd4, 32'd0},
               {1'b0, 3'd4, 32'd0}, {1'b1, 3'd5, 32'd0}};
    stat_seq[0] = 32'd1; stat_len = 1; mb_dlen = 32'd5;
    tx_mem[0] = 32'h1111_1111; tx_mem[1] = 32'h2222_2222; tx_rd = 0; tx_n = 2; tx_en = 1'b1;
    d0 = done_cnt;
    start_txn(32'hA5A5_0001, 32'd8);
    wait_done("dr", 100, n);
    repeat (2) @(negedge clk);
    check("dr_acc_count", acc_q.size(), 11);
    for (int i = 0; i < 11; i++)
      if (i < acc_q.size()) check($sformatf("dr_acc%0d", i), acc_q[i], exp_dr[i]);
    check("dr_resp_dlen", resp_dlen, 32'd5);
    check("dr_resp_status", resp_status, 4'd1);
    check("dr_errors", {err_oversize, err_fail, err_timeout}, 3'd0);
    check("dr_done_pulses", done_cnt - d0, 1);
    check("dr_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("dr_rx0", rx_q[0], 32'hD000_0000);
      check("dr_rx1", rx_q[1], 32'hD000_0001);
    end

    // Lock contention, plus a start pulse while busy that must be ignored
    lock_left = 10; stat_seq[0] = 32'd2; stat_len = 1; tx_n = 0; tx_rd = 0;
    d0 = done_cnt;
    start_txn(32'hC0DE_0002, 32'd0);
    @(posedge clk); #1 start = 1'b1; cmd = 32'hFFFF_FFFF; dlen = 32'h0010_0000;
    @(posedge clk); #1 start = 1'b0;
    wait_done("lock", 100, n);
    repeat (3) @(negedge clk);
    check("lock_reads", n_acc({1'b0, 3'd0}), 11);
    if (acc_q.size() > 11) check("lock_then_cmd", acc_q[11], {1'b1, 3'd1, 32'hC0DE_0002});
    check("busy_start_ignored_err", {63'd0, err_oversize}, 64'd0);
    check("busy_start_ignored_done", done_cnt - d0, 1);

    // Oversize request: straight to DONE, no mailbox access
    start_txn(32'h0000_0003, 32'h0010_0000);
    wait_done("ovs", 10, n);
    check("ovs_done_latency", n, 1);
    check("ovs_busy_in_done", {63'd0, busy}, 64'd1);
    check("ovs_err", {63'd0, err_oversize}, 64'd1);
    check("ovs_no_req_dv", dv_cnt, 0);

    // DATAIN stall with toggling tx_valid
    stat_seq[0] = 32'd2; stat_len = 1; stab_viol = 0;
    tx_mem[0] = 32'hA1A1_0001; tx_mem[1] = 32'hA2A2_0002; tx_mem[2] = 32'hA3A3_0003;
    tx_rd = 0; tx_n = 3; tx_en = 1'b0;
    start_txn(32'h0000_0005, 32'd12);
    wait_addr("stall", 3'd3);
    @(posedge clk); #1 tx_en = 1'b1;
    @(posedge clk); #1 tx_en = 1'b0;
    @(posedge clk); #1 tx_en = 1'b1; req_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_bus%0d", i), {req_dv, req_write, req_addr, req_wdata, tx_ready},
            {1'b1, 1'b1, 3'd3, 32'hA2A2_0002, 1'b0});
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 req_hold = 1'b0;
    @(posedge clk); #1 tx_en = 1'b0;
    @(posedge clk); #1 tx_en = 1'b1;
    wait_done("stall", 60, n);
    din.delete();
    foreach (acc_q[i]) if (acc_q[i][35:32] == {1'b1, 3'd3}) din.push_back(acc_q[i][31:0]);
    check("stall_datain_count", din.size(), 3);
    if (din.size() == 3) begin
      check("stall_datain0", din[0], 32'hA1A1_0001);
      check("stall_datain1", din[1], 32'hA2A2_0002);
      check("stall_datain2", din[2], 32'hA3A3_0003);
    end
    check("stall_stable", stab_viol, 0);
    check("stall_err_cleared", {63'd0, err_oversize}, 64'd0);

    // CMD_FAILURE after two busy polls
    stat_seq[0] = 32'd0; stat_seq[1] = 32'd0; stat_seq[2] = 32'd3; stat_len = 3; tx_n = 0; tx_rd = 0;
    start_txn(32'h0000_0006, 32'd0);
    wait_done("fail", 60, n);
    check("fail_err", {err_fail, err_timeout}, 2'b10);
    check("fail_status", resp_status, 4'd3);
    check("fail_status_reads", n_acc({1'b0, 3'd6}), 3);
    check("fail_no_dataout", n_acc({1'b0, 3'd4}), 0);
    check("fail_acc_count", acc_q.size(), 8);
    if (acc_q.size() > 0) check("fail_release", acc_q[acc_q.size() - 1], {1'b1, 3'd5, 32'd0});

    // Response backpressure: one DATAOUT outstanding at most
    stat_seq[0] = 32'd1; stat_len = 1; mb_dlen = 32'd12; rx_ready = 1'b0; ovr_viol = 0;
    start_txn(32'h0000_0007, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid) break;
    end
    check("bp_rx_valid", {63'd0, rx_valid}, 64'd1);
    repeat (5) @(negedge clk);
    check("bp_one_read", n_acc({1'b0, 3'd4}), 1);
    check("bp_rx_data", rx_data, 32'hD000_0000);
    check("bp_dv_low", {62'd0, req_dv, busy}, 64'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_done("bp", 60, n);
    repeat (2) @(negedge clk);
    check("bp_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) check("bp_rx_words", {rx_q[0][7:0], rx_q[1][7:0], rx_q[2][7:0]}, 24'h000102);
    check("bp_no_overwrite", ovr_viol, 0);
    check("bp_resp_dlen", resp_dlen, 32'd12);

`ifdef CALIPTRA_MBOX_SENDER_TIMEOUT_EN
    // STATUS never leaves CMD_BUSY; gives up after 16 polls
    stat_len = 0; stat_dflt = 32'd0;
    start_txn(32'h0000_0008, 32'd0);
    wait_done("to", 100, n);
    check("to_err", {err_timeout, err_fail}, 2'b10);
    check("to_status_reads", n_acc({1'b0, 3'd6}), 16);
    if (acc_q.size() > 0) check("to_release", acc_q[acc_q.size() - 1], {1'b1, 3'd5, 32'd0});
`endif

    // Reset in the middle of DATA, then a normal transaction
    tx_mem[0] = 32'hBEEF_0001; tx_rd = 0; tx_n = 1; tx_en = 1'b0;
    start_txn(32'h0000_0009, 32'd8);
    wait_addr("rstmid", 3'd3);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rstmid_ctrl", {58'd0, busy, done, req_dv, req_write, tx_ready, rx_valid}, 64'd0);
    check("rstmid_bus", {29'd0, req_addr, req_wdata}, 64'd0);
    check("rstmid_resp", {28'd0, resp_status, resp_dlen}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    stat_seq[0] = 32'd2; stat_len = 1; tx_rd = 0; tx_n = 1; tx_en = 1'b1;
    start_txn(32'h0000_000A, 32'd4);
    wait_done("post_rst", 60, n);
    check("post_rst_acc_count", acc_q.size(), 7);
    check("post_rst_status", resp_status, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
